bcd_range_counter: RTL
======================

Name: bcd_range_counter

Overview:
Parametrised two-digit BCD counter with programmable range MIN..MAX, the next generation of the fixed 00–23 hour counter. One instance serves the digital clock's hours (00–23 or 01–12), minutes and seconds (00–59). It adds up/down counting, synchronous preset load for time setting, a terminal-count output for cascading, and defined recovery from illegal states. The block sits between the 1 Hz timebase or the lower-stage TC and the display decoder.

Parameters:
MIN, 0, lowest count value as a decimal integer; legal range 0..98.
MAX, 23, highest count value as a decimal integer; legal range MIN+1..99.

Ports:
CP  input  1  clock, rising edge active
nCR  input  1  asynchronous reset, active low
En  input  1  count enable, active high
Load  input  1  synchronous preset load, active high; takes priority over En
Up  input  1  direction: 1 counts up, 0 counts down
DH  input  4  preset tens digit (BCD)
DL  input  4  preset units digit (BCD)
CH  output  4  tens digit (BCD), registered
CL  output  4  units digit (BCD), registered
TC  output  1  terminal count, combinational

Behaviour:
- Value notation: V = 10*CH + CL. A state is legal when CH<=9, CL<=9 and MIN<=V<=MAX.
- Reset: nCR=0 asynchronously forces {CH,CL} to the BCD of MIN, independent of CP. Release of reset is synchronous to the next CP edge. There is no initial block; the reset is the only initialiser.
- Priority on each rising CP edge, highest first: nCR, then Load, then En, otherwise hold.
- Load=1: if {DH,DL} is legal, load it. Otherwise load BCD(MIN). Load acts regardless of En and Up.
- En=0 and Load=0: hold CH and CL.
- En=1, Up=1, legal state:
  - V==MAX wraps to MIN.
  - CL==9 sets CL=0 and CH=CH+1.
  - Any other state sets CL=CL+1.
- En=1, Up=0, legal state:
  - V==MIN wraps to MAX.
  - CL==0 sets CL=9 and CH=CH-1.
  - Any other state sets CL=CL-1.
- En=1, illegal state (any digit>9, V<MIN or V>MAX): go to MIN when Up=1, or MAX when Up=0. Exactly one enabled edge recovers the counter.
- TC = En & ~Load & (Up ? (V==MAX) : (V==MIN)). TC must be 0 in any illegal state. TC is high during the cycle before a wrap, so it can drive the next stage's En directly.
- Latency: one CP edge from En, Load or Up to the new count. TC follows the inputs combinationally with no delay.
- Width rules:
  - Digit arithmetic is done in 4 bits.
  - MIN and MAX are converted to BCD at elaboration (tens = N/10, units = N%10).
  - No binary intermediate wider than 7 bits.
- Direction change mid-count takes effect on the next enabled edge, with no skipped or repeated value.
- Reset asserted mid-operation overrides a simultaneous Load or count.

Test Plan:
1. Default parameters, reset, En=1 Up=1 for 30 edges -> sequence 00,01..09,10..23,00,01..06. TC=1 only while 23 is displayed.
2. MIN=1 MAX=12, reset -> 01. Count down 3 edges -> 12,11,10 (wrap from 01 to 12). TC=1 while 01 is displayed with Up=0.
3. MIN=0 MAX=59, Load=1 with DH=5 DL=8 and En=0 -> 58. Next, Load=1 with DH=7 DL=3 -> 00 (illegal preset rejected).
4. Default parameters, force illegal 2_A via Load bypass (hierarchical force), En=1 Up=0 -> 23 after one edge. TC=0 while illegal.
5. Load=1 and En=1 on the same edge at value 05 with preset 17 -> 17, not 06. Then nCR pulsed low between edges -> 00 immediately, before the next CP.
6. Cascade: a seconds instance (0..59) whose TC drives the En of a minutes instance (0..59), run 3600 edges -> minutes 59→00 and seconds 59→00 on the same edge. Each minutes step coincides with seconds TC=1.

Source files
------------

// File: rtl/bcd_range_counter.sv
// ============================================================================
// bcd_range_counter : two-digit BCD up/down counter over MIN..MAX
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_range_counter #(
  parameter int MIN = 0,
  parameter int MAX = 23
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       En,
  input  logic       Load,
  input  logic       Up,
  input  logic [3:0] DH,
  input  logic [3:0] DL,
  output logic [3:0] CH,
  output logic [3:0] CL,
  output logic       TC
);

  localparam logic [3:0] MIN_H = 4'(MIN / 10);
  localparam logic [3:0] MIN_L = 4'(MIN % 10);
  localparam logic [3:0] MAX_H = 4'(MAX / 10);
  localparam logic [3:0] MAX_L = 4'(MAX % 10);

  logic [3:0] ch_q;
  logic [3:0] cl_q;
  logic [3:0] ch_nxt;
  logic [3:0] cl_nxt;
  logic       cur_legal;
  logic       preset_legal;
  logic       at_max;
  logic       at_min;

  // Range comparison is done digit-wise so no binary value is ever formed.
  function automatic logic is_legal(input logic [3:0] h, input logic [3:0] l);
    logic digits_ok;
    logic ge_min;
    logic le_max;
    digits_ok = (h <= 4'd9) && (l <= 4'd9);
    ge_min    = (h > MIN_H) || ((h == MIN_H) && (l >= MIN_L));
    le_max    = (h < MAX_H) || ((h == MAX_H) && (l <= MAX_L));
    return digits_ok && ge_min && le_max;
  endfunction

  always_comb begin
    cur_legal    = is_legal(ch_q, cl_q);
    preset_legal = is_legal(DH, DL);
    at_max       = (ch_q == MAX_H) && (cl_q == MAX_L);
    at_min       = (ch_q == MIN_H) && (cl_q == MIN_L);
  end

  always_comb begin
    ch_nxt = ch_q;
    cl_nxt = cl_q;
    if (Load) begin
      if (preset_legal) begin
        ch_nxt = DH;
        cl_nxt = DL;
      end else begin
        ch_nxt = MIN_H;
        cl_nxt = MIN_L;
      end
    end else if (En) begin
      if (!cur_legal) begin
        // A single enabled edge lands on the end the counter is heading away from.
        ch_nxt = Up ? MIN_H : MAX_H;
        cl_nxt = Up ? MIN_L : MAX_L;
      end else if (Up) begin
        if (at_max) begin
          ch_nxt = MIN_H;
          cl_nxt = MIN_L;
        end else if (cl_q == 4'd9) begin
          ch_nxt = ch_q + 4'd1;
          cl_nxt = 4'd0;
        end else begin
          cl_nxt = cl_q + 4'd1;
        end
      end else begin
        if (at_min) begin
          ch_nxt = MAX_H;
          cl_nxt = MAX_L;
        end else if (cl_q == 4'd0) begin
          ch_nxt = ch_q - 4'd1;
          cl_nxt = 4'd9;
        end else begin
          cl_nxt = cl_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      ch_q <= MIN_H;
      cl_q <= MIN_L;
    end else begin
      ch_q <= ch_nxt;
      cl_q <= cl_nxt;
    end
  end

  assign CH = ch_q;
  assign CL = cl_q;
  assign TC = En & ~Load & cur_legal & (Up ? at_max : at_min);

endmodule

`default_nettype wire
